// File: rtl/wb_mem_loader.sv
// Wishbone loader for the instruction/data SRAMs; parks the core until CTRL.run is set.
// state | meaning
// IDLE  | waiting for a hit in the BASE_ADDR window
// WR    | one-clock SRAM write strobe
// RA    | SRAM address presented for a read
// RD    | SRAM Q valid, captured into the read buffer
// ACK   | single-clock wishbone acknowledge
module wb_mem_loader #(
   parameter logic [15:0] BASE_ADDR = 16'h3000,
   parameter int          AW        = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          wbs_cyc_i,
   input  logic          wbs_stb_i,
   input  logic          wbs_we_i,
   input  logic [3:0]    wbs_sel_i,
   input  logic [31:0]   wbs_adr_i,
   input  logic [31:0]   wbs_dat_i,
   output logic          wbs_ack_o,
   output logic [31:0]   wbs_dat_o,
   output logic          mem_sel_i,
   output logic          mem_sel_d,
   output logic [1:0]    mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata,
   input  logic [15:0]   instr_rdata,
   input  logic [15:0]   data_rdata,
   input  logic          hlt,
   output logic          run,
   output logic          start
);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RA, S_RD, S_ACK} state_t;

   state_t        state_q, state_d;
   logic          rearm_q, rearm_d;
   logic          abort_q, abort_d;
   logic          is_data_q, is_data_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [15:0]   wdata_q, wdata_d;
   logic [1:0]    be_q, be_d;
   logic [15:0]   rdata_q, rdata_d;
   logic          run_q, run_d;
   logic          start_q, start_d;
   logic          err_q, err_d;
   logic          hlt_q;

   logic [15:0] off;
   logic        req, hit, take, in_mem, is_data, is_ctrl, is_stat, mem_act;
   logic        unused_ok;

   assign unused_ok = ^{wbs_sel_i[3:2], wbs_dat_i[31:16]};
   assign off       = wbs_adr_i[15:0];
   assign req       = wbs_cyc_i & wbs_stb_i;
   // rearm_q blocks a strobe still held high from the transfer just acknowledged
   assign hit       = req & (wbs_adr_i[31:16] == BASE_ADDR) & ~rearm_q;
   assign take      = (state_q == S_IDLE) & hit;
   assign in_mem    = off < 16'h0800;
   assign is_data   = off[10];
   assign is_ctrl   = off == 16'h0800;
   assign is_stat   = off == 16'h0804;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (hit) state_d = (in_mem & ~run_q) ? (wbs_we_i ? S_WR : S_RA) : S_ACK;
         S_WR:    state_d = (req & ~abort_q) ? S_ACK : S_IDLE;
         S_RA:    state_d = S_RD;
         S_RD:    state_d = (req & ~abort_q) ? S_ACK : S_IDLE;
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_act   = (state_q == S_WR) | (state_q == S_RA) | (state_q == S_RD);
      wbs_ack_o = state_q == S_ACK;
      wbs_dat_o = wbs_ack_o ? {16'h0000, rdata_q} : 32'h0;
      mem_sel_i = mem_act & ~is_data_q;
      mem_sel_d = mem_act & is_data_q;
      mem_we    = (state_q == S_WR) ? be_q : 2'b00;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      run       = run_q;
      start     = start_q;
   end

   always_comb begin
      rearm_d   = (state_q == S_ACK) ? req : (rearm_q & req);
      abort_d   = (state_q == S_IDLE) ? 1'b0 : (abort_q | ~req);
      is_data_d = is_data_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      rdata_d   = rdata_q;
      run_d     = run_q;
      start_d   = 1'b0;
      err_d     = err_q;
      if (take) begin
         rdata_d = 16'h0000;
         if (in_mem) begin
            // the core owns the SRAMs while running: refuse the access and flag it
            if (run_q) begin
               err_d = 1'b1;
            end else begin
               is_data_d = is_data;
               addr_d    = wbs_adr_i[AW+1:2];
               be_d      = wbs_we_i ? wbs_sel_i[1:0] : 2'b00;
               if (wbs_we_i) wdata_d = wbs_dat_i[15:0];
            end
         end else if (is_ctrl) begin
            if (wbs_we_i) begin
               run_d   = wbs_dat_i[0];
               start_d = wbs_dat_i[0] & ~run_q;
            end else begin
               rdata_d = {15'b0, run_q};
            end
         end else if (is_stat) begin
            if (wbs_we_i) begin
               if (wbs_dat_i[1]) err_d = 1'b0;
            end else begin
               rdata_d = {14'b0, err_q, hlt_q};
            end
         end
      end
      if (state_q == S_RD) rdata_d = is_data_q ? data_rdata : instr_rdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rearm_q   <= 1'b0;
         abort_q   <= 1'b0;
         is_data_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= 16'h0000;
         be_q      <= 2'b00;
         rdata_q   <= 16'h0000;
         run_q     <= 1'b0;
         start_q   <= 1'b0;
         err_q     <= 1'b0;
         hlt_q     <= 1'b0;
      end else begin
         rearm_q   <= rearm_d;
         abort_q   <= abort_d;
         is_data_q <= is_data_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         rdata_q   <= rdata_d;
         run_q     <= run_d;
         start_q   <= start_d;
         err_q     <= err_d;
         hlt_q     <= hlt;
      end
   end

endmodule

// File: tb/tb_wb_mem_loader.sv
// Directed bench for wb_mem_loader: a rule-level model predicts every transfer, a per-cycle
// monitor checks run/start/idle outputs, and SRAMs are modelled behind the loader port.
module tb_wb_mem_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        mem_sel_i, mem_sel_d;
   logic [1:0]  mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] instr_rdata, data_rdata;
   logic        hlt;
   logic        run, start;

   always #5 clk = ~clk;

   wb_mem_loader #(.BASE_ADDR(16'h3000), .AW(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
      .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
      .mem_sel_i(mem_sel_i), .mem_sel_d(mem_sel_d), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .instr_rdata(instr_rdata), .data_rdata(data_rdata),
      .hlt(hlt), .run(run), .start(start)
   );

   // SRAM environment: registered Q, per-byte write enables
   logic [15:0] sram_i [256];
   logic [15:0] sram_d [256];
   always @(posedge clk) begin
      if (mem_sel_i) begin
         if (mem_we[0]) sram_i[mem_addr][7:0]  <= mem_wdata[7:0];
         if (mem_we[1]) sram_i[mem_addr][15:8] <= mem_wdata[15:8];
         instr_rdata <= sram_i[mem_addr];
      end
      if (mem_sel_d) begin
         if (mem_we[0]) sram_d[mem_addr][7:0]  <= mem_wdata[7:0];
         if (mem_we[1]) sram_d[mem_addr][15:8] <= mem_wdata[15:8];
         data_rdata <= sram_d[mem_addr];
      end
   end

   int checks   = 0;
   int failures = 0;
   int cyc_cnt  = 0;
   int start_at = -100;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // reference model state
   logic        m_run = 1'b0;
   logic        m_err = 1'b0;
   logic [15:0] exp_i [256];
   logic [15:0] exp_d [256];
   logic        chk_en = 1'b0;

   logic        e_ack, e_si, e_sd, p_run_v, p_run, p_start;
   int          e_lat, e_op;
   logic [31:0] e_rd;
   logic [7:0]  e_addr;
   logic [1:0]  e_we;
   logic [15:0] e_wd;

   int          obs_lat, obs_wec;
   logic [31:0] obs_rd;
   logic        obs_si, obs_sd;
   logic [7:0]  obs_addr;
   logic [1:0]  obs_we1;
   logic [15:0] obs_wd;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%h expected 0x%h", nm, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("run level", {31'b0, run}, {31'b0, m_run});
         check("start pulse", {31'b0, start}, {31'b0, cyc_cnt == start_at});
         if (!wbs_ack_o) check("dat_o idle", wbs_dat_o, 32'h0);
         check("sram selects exclusive", {31'b0, mem_sel_i & mem_sel_d}, 32'h0);
         if (mem_we != 2'b00) check("we without select", {31'b0, mem_sel_i | mem_sel_d}, 32'h1);
      end
   end

   task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [15:0] o;
      logic [7:0]  wi;
      o = a[15:0];
      wi = a[9:2];
      e_ack = 1'b0; e_lat = 0; e_rd = 32'h0; e_op = 0; e_si = 1'b0; e_sd = 1'b0;
      e_addr = 8'h0; e_we = 2'b00; e_wd = 16'h0; p_run_v = 1'b0; p_run = m_run; p_start = 1'b0;
      if (a[31:16] == 16'h3000) begin
         e_ack = 1'b1;
         e_lat = 1;
         if (o < 16'h0800) begin
            if (m_run) begin
               m_err = 1'b1;
            end else begin
               e_op   = w ? 1 : 2;
               e_lat  = w ? 2 : 3;
               e_si   = o < 16'h0400;
               e_sd   = !e_si;
               e_addr = wi;
               if (w) begin
                  e_we = s[1:0];
                  e_wd = d[15:0];
                  if (e_si) begin
                     if (s[0]) exp_i[wi][7:0]  = d[7:0];
                     if (s[1]) exp_i[wi][15:8] = d[15:8];
                  end else begin
                     if (s[0]) exp_d[wi][7:0]  = d[7:0];
                     if (s[1]) exp_d[wi][15:8] = d[15:8];
                  end
               end else begin
                  e_rd = {16'h0, e_sd ? exp_d[wi] : exp_i[wi]};
               end
            end
         end else if (o == 16'h0800) begin
            if (w) begin
               p_run_v = 1'b1;
               p_run   = d[0];
               p_start = d[0] && !m_run;
            end else begin
               e_rd = {31'b0, m_run};
            end
         end else if (o == 16'h0804) begin
            if (w) begin
               if (d[1]) m_err = 1'b0;
            end else begin
               e_rd = {30'b0, m_err, hlt};
            end
         end
      end
   endtask

   // called 1 ns after a clock edge with the DUT idle
   task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input string nm);
      logic got;
      model(w, a, d, s);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
      got = 1'b0; obs_lat = 0; obs_wec = 0; obs_rd = 32'h0;
      for (int n = 1; n <= 6 && !got; n++) begin
         @(posedge clk); #1;
         if (n == 1 && p_run_v) begin
            m_run = p_run;
            if (p_start) start_at = cyc_cnt;
         end
         if (mem_we != 2'b00) obs_wec++;
         if (n == 1) begin
            obs_si = mem_sel_i; obs_sd = mem_sel_d; obs_addr = mem_addr;
            obs_we1 = mem_we; obs_wd = mem_wdata;
         end
         if (wbs_ack_o) begin
            got = 1'b1; obs_lat = n; obs_rd = wbs_dat_o;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      if (e_ack) check({nm, " ack latency"}, obs_lat, e_lat);
      else       check({nm, " no ack"}, obs_lat, 0);
      if (e_ack && !w) check({nm, " rdata"}, obs_rd, e_rd);
      check({nm, " we cycles"}, obs_wec, (e_op == 1) ? 1 : 0);
      check({nm, " sel_i"}, {31'b0, obs_si}, {31'b0, e_si});
      check({nm, " sel_d"}, {31'b0, obs_sd}, {31'b0, e_sd});
      if (e_op != 0) begin
         check({nm, " addr"}, {24'b0, obs_addr}, {24'b0, e_addr});
         check({nm, " we"}, {30'b0, obs_we1}, {30'b0, e_we});
      end
      if (e_op == 1) check({nm, " wdata"}, {16'b0, obs_wd}, {16'b0, e_wd});
   endtask

   initial begin
      int acks;
      reset_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
      adr = 32'h0; dat_i = 32'h0; hlt = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst ack", {31'b0, wbs_ack_o}, 32'h0);
      check("rst dat_o", wbs_dat_o, 32'h0);
      check("rst sel_i", {31'b0, mem_sel_i}, 32'h0);
      check("rst sel_d", {31'b0, mem_sel_d}, 32'h0);
      check("rst we", {30'b0, mem_we}, 32'h0);
      check("rst addr", {24'b0, mem_addr}, 32'h0);
      check("rst wdata", {16'b0, mem_wdata}, 32'h0);
      check("rst run", {31'b0, run}, 32'h0);
      check("rst start", {31'b0, start}, 32'h0);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;

      xfer(1'b1, 32'h3000_0008, 32'h0000_BEEF, 4'b0011, "t1 write");
      check("t1 lat literal", obs_lat, 2);
      check("t1 addr literal", {24'b0, obs_addr}, 32'd2);
      check("t1 we literal", {30'b0, obs_we1}, 32'h3);
      check("t1 wdata literal", {16'b0, obs_wd}, 32'hBEEF);
      check("t1 sel_i literal", {31'b0, obs_si}, 32'h1);
      xfer(1'b0, 32'h3000_0008, 32'h0, 4'b0011, "t2 read");
      check("t2 lat literal", obs_lat, 3);
      check("t2 rdata literal", obs_rd, 32'h0000_BEEF);
      xfer(1'b1, 32'h3000_0008, 32'h0000_1234, 4'b0010, "t2 msb write");
      check("t2 msb we literal", {30'b0, obs_we1}, 32'h2);
      xfer(1'b0, 32'h3000_0008, 32'h0, 4'b0011, "t2 msb read");
      check("t2 merged literal", obs_rd, 32'h0000_12EF);
      xfer(1'b1, 32'h3000_0404, 32'h0000_A5A5, 4'b0011, "data write");
      xfer(1'b0, 32'h3000_0404, 32'h0, 4'b0011, "data read");
      check("data read literal", obs_rd, 32'h0000_A5A5);

      xfer(1'b1, 32'h3000_0800, 32'h1, 4'b0001, "t3 run on");
      check("t3 run literal", {31'b0, run}, 32'h1);
      xfer(1'b1, 32'h3000_0800, 32'h1, 4'b0001, "t3 run again");
      xfer(1'b0, 32'h3000_0800, 32'h0, 4'b0001, "t3 ctrl read");
      check("t3 ctrl literal", obs_rd, 32'h1);

      xfer(1'b1, 32'h3000_0404, 32'h0000_5555, 4'b0011, "t4 write while run");
      check("t4 lat literal", obs_lat, 1);
      check("t4 no strobe literal", obs_wec, 0);
      xfer(1'b0, 32'h3000_0008, 32'h0, 4'b0011, "t4 read while run");
      xfer(1'b0, 32'h3000_0804, 32'h0, 4'b0001, "t4 status");
      check("t4 status literal", obs_rd, 32'h2);
      xfer(1'b1, 32'h3000_0804, 32'h2, 4'b0001, "t4 w1c");
      xfer(1'b0, 32'h3000_0804, 32'h0, 4'b0001, "t4 status cleared");
      check("t4 cleared literal", obs_rd, 32'h0);
      xfer(1'b1, 32'h3000_0800, 32'h0, 4'b0001, "t3 run off");
      check("t3 run off literal", {31'b0, run}, 32'h0);
      xfer(1'b0, 32'h3000_0404, 32'h0, 4'b0011, "t4 data intact");

      hlt = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      xfer(1'b0, 32'h3000_0804, 32'h0, 4'b0001, "hlt status");
      check("hlt status literal", obs_rd, 32'h1);
      hlt = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      xfer(1'b1, 32'h3000_03FC, 32'h0000_7777, 4'b0011, "t5 top instr");
      check("t5 top addr literal", {24'b0, obs_addr}, 32'd255);
      check("t5 top sel_i literal", {31'b0, obs_si}, 32'h1);
      xfer(1'b1, 32'h3000_0400, 32'h0000_8888, 4'b0011, "t5 data zero");
      check("t5 data addr literal", {24'b0, obs_addr}, 32'd0);
      check("t5 data sel_d literal", {31'b0, obs_sd}, 32'h1);
      xfer(1'b0, 32'h3000_03FC, 32'h0, 4'b0011, "t5 top read");
      xfer(1'b1, 32'h3001_0000, 32'h0000_1111, 4'b0011, "t5 miss");
      check("t5 miss literal", obs_lat, 0);
      xfer(1'b0, 32'h3000_0900, 32'h0, 4'b0011, "t5 unmapped read");

      xfer(1'b1, 32'h3000_0800, 32'h1, 4'b0001, "t6 run on");
      xfer(1'b1, 32'h3000_0008, 32'h0000_9999, 4'b0011, "t6 set err");
      xfer(1'b1, 32'h3000_0800, 32'h0, 4'b0001, "t6 run off");
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0400; sel = 4'b0011;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b0;
      m_run = 1'b0;
      m_err = 1'b0;
      acks = 0;
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); #1;
         if (wbs_ack_o) acks++;
      end
      check("t6 ack suppressed", acks, 0);
      check("t6 run cleared", {31'b0, run}, 32'h0);
      check("t6 dat_o cleared", wbs_dat_o, 32'h0);
      cyc = 1'b0; stb = 1'b0;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      xfer(1'b0, 32'h3000_0804, 32'h0, 4'b0001, "t6 status after reset");
      check("t6 status literal", obs_rd, 32'h0);
      xfer(1'b0, 32'h3000_0400, 32'h0, 4'b0011, "t6 read after reset");
      check("t6 read literal", obs_rd, 32'h0000_8888);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
